// File: rtl/key_press_conditioner_pkg.sv
// Shared types and defaults for the tug-of-war button input stage.
// The key state doubles as the accepted (debounced) button level.
package tow_pkg;

    typedef enum logic {
        KEY_RELEASED = 1'b0,
        KEY_PRESSED  = 1'b1
    } key_state_t;

    localparam int DEBOUNCE_DEFAULT = 16;

endpackage

// File: rtl/key_press_conditioner_if.sv
// Button-side and move-pulse-side signals of the key press conditioner.
// The master drives the raw active-low keys; the slave returns the move pulses.
interface key_press_conditioner_if;

    logic KEY_L;
    logic KEY_R;
    logic L;
    logic R;

    modport master (
        output KEY_L,
        output KEY_R,
        input  L,
        input  R
    );

    modport slave (
        input  KEY_L,
        input  KEY_R,
        output L,
        output R
    );

endinterface

// File: rtl/key_press_conditioner_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, and a press FSM
// that emits a single registered pulse per accepted press.
module key_debounce_pulse
    import tow_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncMeta_q;
    logic             syncLevel_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    key_state_t       state_q;
    key_state_t       sampled;
    logic             levelAccepted;
    logic             pulse_q;

    // A synced level differing from the accepted one must persist for
    // DEBOUNCE_CYCLES consecutive edges; any return to the accepted level
    // clears the count so short glitches are never accepted.
    always_comb begin
        sampled       = key_state_t'(syncLevel_q);
        count_d       = count_q;
        levelAccepted = 1'b0;
        if (sampled == state_q) begin
            count_d = '0;
        end else if (count_q == COUNT_LAST) begin
            count_d       = '0;
            levelAccepted = 1'b1;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Reset treats the key as already pressed, so a key held through reset
    // must be seen released before it can generate a move.
    always_ff @(posedge clk) begin
        if (reset) begin
            syncMeta_q  <= 1'b1;
            syncLevel_q <= 1'b1;
            count_q     <= '0;
            state_q     <= KEY_PRESSED;
            pulse_q     <= 1'b0;
        end else begin
            syncMeta_q  <= ~key_n;
            syncLevel_q <= syncMeta_q;
            count_q     <= count_d;
            pulse_q     <= 1'b0;
            case (state_q)
                KEY_RELEASED: begin
                    if (levelAccepted) begin
                        state_q <= KEY_PRESSED;
                        pulse_q <= 1'b1;
                    end
                end
                KEY_PRESSED: begin
                    if (levelAccepted) begin
                        state_q <= KEY_RELEASED;
                    end
                end
                default: state_q <= KEY_PRESSED;
            endcase
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/key_press_conditioner.sv
// Input stage for the tug-of-war game: two independent button channels
// turning raw active-low keys into one move pulse per press.
module key_press_conditioner
    import tow_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    key_press_conditioner_if.slave  keyIf
);

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) leftChannel (
        .clk   (clk),
        .reset (reset),
        .key_n (keyIf.KEY_L),
        .pulse (keyIf.L)
    );

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) rightChannel (
        .clk   (clk),
        .reset (reset),
        .key_n (keyIf.KEY_R),
        .pulse (keyIf.R)
    );

endmodule

// File: tb/tb_key_press_conditioner.sv
// Directed bench for key_press_conditioner with DEBOUNCE_CYCLES=4: a press
// first sampled at edge 0 must pulse only in the cycle after edge 5.
module tb_key_press_conditioner;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    key_press_conditioner_if keyIf ();

    key_press_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .keyIf (keyIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive the keys at a negedge, then check L/R after each of n edges;
    // pulseL/pulseR give the edge index (from 0) after which a pulse is due, -1 for none.
    task automatic applyStimulus(input logic keyL, input logic keyR, input int n,
                                 input int pulseL, input int pulseR, input string tag);
        keyIf.KEY_L = keyL;
        keyIf.KEY_R = keyR;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, " L"}, keyIf.L, logic'(k == pulseL));
            checkOutput({tag, " R"}, keyIf.R, logic'(k == pulseR));
        end
    endtask

    task automatic doReset(input int n, input logic keyL, input logic keyR, input string tag);
        reset = 1'b1;
        keyIf.KEY_L = keyL;
        keyIf.KEY_R = keyR;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, " rst L"}, keyIf.L, 1'b0);
            checkOutput({tag, " rst R"}, keyIf.R, 1'b0);
        end
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        keyIf.KEY_L = 1'b1;
        keyIf.KEY_R = 1'b1;
        @(negedge clk);

        // Idle after reset: keys settle to released silently.
        doReset(3, 1'b1, 1'b1, "t1");
        applyStimulus(1'b1, 1'b1, 20, -1, -1, "t1 idle");

        // Held left press: exactly one pulse after edge 5; release is silent.
        applyStimulus(1'b0, 1'b1, 20, 5, -1, "t2 hold");
        applyStimulus(1'b1, 1'b1, 10, -1, -1, "t2 release");

        // Right bounce 0,0,1,0,0,0,1 never reaches four stable cycles.
        applyStimulus(1'b0, 1'b1, 1, -1, -1, "t3 b0");
        applyStimulus(1'b1, 1'b0, 1, -1, -1, "t3 b1");
        applyStimulus(1'b1, 1'b0, 1, -1, -1, "t3 b2");
        applyStimulus(1'b1, 1'b1, 1, -1, -1, "t3 b3");
        applyStimulus(1'b1, 1'b0, 1, -1, -1, "t3 b4");
        applyStimulus(1'b1, 1'b0, 1, -1, -1, "t3 b5");
        applyStimulus(1'b1, 1'b0, 1, -1, -1, "t3 b6");
        applyStimulus(1'b1, 1'b1, 8, -1, -1, "t3 b7");
        applyStimulus(1'b1, 1'b0, 10, -1, 5, "t3 press");
        applyStimulus(1'b1, 1'b1, 10, -1, -1, "t3 release");

        // Simultaneous presses pulse together, once each.
        applyStimulus(1'b0, 1'b0, 10, 5, 5, "t4 both");
        applyStimulus(1'b1, 1'b1, 10, -1, -1, "t4 release");

        // Key held through reset gives nothing until released and re-pressed.
        applyStimulus(1'b0, 1'b1, 2, -1, -1, "t5 pre");
        doReset(3, 1'b0, 1'b1, "t5");
        applyStimulus(1'b0, 1'b1, 10, -1, -1, "t5 held");
        applyStimulus(1'b1, 1'b1, 6, -1, -1, "t5 release");
        applyStimulus(1'b0, 1'b1, 10, 5, -1, "t5 repress");
        applyStimulus(1'b1, 1'b1, 10, -1, -1, "t5 idle");

        // Reset mid-count discards the press in progress.
        applyStimulus(1'b0, 1'b1, 3, -1, -1, "t6 partial");
        doReset(1, 1'b0, 1'b1, "t6");
        applyStimulus(1'b0, 1'b1, 10, -1, -1, "t6 held");
        applyStimulus(1'b1, 1'b1, 10, -1, -1, "t6 release");
        applyStimulus(1'b0, 1'b1, 10, 5, -1, "t6 repress");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
